// File: rtl/btn_sw_pkg.sv
// Shared types and helpers for the push-button event decoder.
package btn_sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT2     = 3'd3,
    ST_PRESS2    = 3'd4
  } btn_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, polarity normalisation and debounce filter for a raw button pin.
module btn_debounce
  import btn_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        BTN_ACTIVE      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db
);

  localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lvl;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign lvl = BTN_ACTIVE ? sync2_q : ~sync2_q;

  // Count consecutive samples disagreeing with the filtered level; flip after a full run.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (lvl == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Debounced push-button classifier emitting short/long/double press strobes.
module btn_event_decoder
  import btn_sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 1024,
  parameter int unsigned DOUBLE_GAP      = 256,
  parameter logic        BTN_ACTIVE      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic held,
  output logic double_press
);

  localparam int unsigned      EV_W      = cnt_width(max3(LONG_CYCLES, DOUBLE_GAP, DEBOUNCE_CYCLES));
  localparam logic [EV_W-1:0]  LONG_LAST = EV_W'(LONG_CYCLES - 1);
  localparam logic [EV_W-1:0]  GAP_LAST  = EV_W'(DOUBLE_GAP - 1);

  btn_state_e      state_q;
  btn_state_e      state_d;
  logic [EV_W-1:0] ev_cnt_q;
  logic [EV_W-1:0] ev_cnt_d;
  logic            db;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            held_q, held_d;
  logic            double_q, double_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE     (BTN_ACTIVE)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .btn_db(db)
  );

  // State, event counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      ev_cnt_q <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_cnt_q <= ev_cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      held_q   <= held_d;
      double_q <= double_d;
    end
  end

  // Next state: a level change always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (db) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (!db)                        state_d = ST_WAIT2;
        else if (ev_cnt_q == LONG_LAST) state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD: if (!db) state_d = ST_IDLE;
      ST_WAIT2: begin
        if (db)                        state_d = ST_PRESS2;
        else if (ev_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      ST_PRESS2:    if (!db) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes decode the transition taken; counter clears on any state entry.
  always_comb begin
    ev_cnt_d = ev_cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    held_d   = (state_d == ST_LONG_HELD);
    if (state_d != state_q) begin
      ev_cnt_d = '0;
    end else if (ev_cnt_q != '1) begin
      ev_cnt_d = ev_cnt_q + EV_W'(1);
    end
    short_d  = (state_q == ST_WAIT2)  && (state_d == ST_IDLE);
    long_d   = (state_q == ST_PRESS1) && (state_d == ST_LONG_HELD);
    double_d = (state_q == ST_PRESS2) && (state_d == ST_IDLE);
  end

  assign btn_db       = db;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign held         = held_q;
  assign double_press = double_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomised and directed bench for btn_event_decoder against a timestamp-based gesture model.
module tb_btn_event_decoder;

  localparam int DB_N   = 4;
  localparam int LONG_N = 20;
  localparam int GAP_N  = 10;

  localparam int PH_IDLE = 0;
  localparam int PH_P1   = 1;
  localparam int PH_LH   = 2;
  localparam int PH_W2   = 3;
  localparam int PH_P2   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic btn_db, short_press, long_press, held, double_press;

  btn_event_decoder #(
    .DEBOUNCE_CYCLES(DB_N),
    .LONG_CYCLES    (LONG_N),
    .DOUBLE_GAP     (GAP_N),
    .BTN_ACTIVE     (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .btn_db      (btn_db),
    .short_press (short_press),
    .long_press  (long_press),
    .held        (held),
    .double_press(double_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: pin pipeline, "last N synchronised samples disagree" filter,
  // and gesture phases timed by elapsed edges since phase entry.
  int     ph = PH_IDLE;
  longint now = 0;
  longint t_ent = 0;
  bit     m_s1, m_s2, m_db;
  bit     hist[$];
  bit     e_short, e_long, e_held, e_double;
  int     n_sh, n_lo, n_do, n_dbhi;

  task automatic model_step();
    bit lvl, seen, all_diff;
    int el, nph;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_double = 1'b0;
    if (!rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
      hist.delete();
      ph = PH_IDLE;
      e_held = 1'b0;
    end else begin
      lvl  = m_s2;
      seen = m_db;
      hist.push_back(lvl);
      if (hist.size() > DB_N) void'(hist.pop_front());
      all_diff = (hist.size() == DB_N);
      foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
      el  = int'(now - t_ent);
      nph = ph;
      case (ph)
        PH_IDLE: if (seen) nph = PH_P1;
        PH_P1: begin
          if (!seen) nph = PH_W2;
          else if (el == LONG_N) begin nph = PH_LH; e_long = 1'b1; end
        end
        PH_LH:   if (!seen) nph = PH_IDLE;
        PH_W2: begin
          if (seen) nph = PH_P2;
          else if (el == GAP_N) begin nph = PH_IDLE; e_short = 1'b1; end
        end
        PH_P2:   if (!seen) begin nph = PH_IDLE; e_double = 1'b1; end
        default: nph = PH_IDLE;
      endcase
      if (nph != ph) begin
        ph    = nph;
        t_ent = now;
      end
      e_held = (ph == PH_LH);
      m_s2 = m_s1;
      m_s1 = btn;
      if (all_diff) m_db = ~m_db;
    end
    now++;
  endtask

  task automatic tick(input bit b, input bit r);
    btn = b;
    rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs{db,sh,lo,held,dbl}",
          {27'd0, btn_db, short_press, long_press, held, double_press},
          {27'd0, m_db, e_short, e_long, e_held, e_double});
    n_sh   += int'(short_press);
    n_lo   += int'(long_press);
    n_do   += int'(double_press);
    n_dbhi += int'(btn_db);
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) tick(b, 1'b1);
  endtask

  task automatic clear_counts();
    n_sh = 0; n_lo = 0; n_do = 0; n_dbhi = 0;
  endtask

  task automatic expect_counts(input string tag, input int sh, input int lo, input int dbl);
    check({tag, "_short"},  n_sh, sh);
    check({tag, "_long"},   n_lo, lo);
    check({tag, "_double"}, n_do, dbl);
  endtask

  initial begin
    clear_counts();
    repeat (3) tick(1'b0, 1'b0);
    hold(1'b0, 5);

    // Bounce: toggling every 2 cycles never qualifies.
    clear_counts();
    for (int i = 0; i < 15; i++) hold(i % 2 == 0, 2);
    hold(1'b0, 20);
    check("bounce_db_high_cycles", n_dbhi, 0);
    expect_counts("bounce", 0, 0, 0);

    clear_counts();
    hold(1'b1, 8); hold(1'b0, 30);
    expect_counts("short", 1, 0, 0);

    clear_counts();
    hold(1'b1, 40); hold(1'b0, 30);
    expect_counts("long", 0, 1, 0);

    clear_counts();
    hold(1'b1, 6); hold(1'b0, 5); hold(1'b1, 6); hold(1'b0, 30);
    expect_counts("double", 0, 0, 1);

    clear_counts();
    hold(1'b1, 6); hold(1'b0, 5); hold(1'b1, 50); hold(1'b0, 30);
    expect_counts("double_hold", 0, 0, 1);

    // Release length around the gap window: up to GAP_N still pairs.
    for (int r = GAP_N - 2; r <= GAP_N + 2; r++) begin
      clear_counts();
      hold(1'b1, 6); hold(1'b0, r); hold(1'b1, 6); hold(1'b0, 40);
      if (r <= GAP_N) expect_counts($sformatf("gap%0d", r), 0, 0, 1);
      else            expect_counts($sformatf("gap%0d", r), 2, 0, 0);
    end

    // Reset during long hold with button still down.
    hold(1'b1, 40);
    clear_counts();
    repeat (3) tick(1'b1, 1'b0);
    check("rst_mid_outputs", n_sh + n_lo + n_do + n_dbhi, 0);
    hold(1'b1, 30); hold(1'b0, 30);
    expect_counts("rst_mid", 0, 1, 0);

    // Random segments: clean levels, bounce bursts and occasional resets.
    repeat (250) begin
      int unsigned mode;
      mode = $urandom_range(0, 99);
      if (mode < 70) begin
        hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 35)));
      end else if (mode < 92) begin
        repeat ($urandom_range(2, 8)) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end else begin
        repeat ($urandom_range(1, 3)) tick(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    hold(1'b0, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Turns a raw mechanical push-button into debounced, classified one-cycle event pulses: short press, long press and double press. It also exposes the debounced level. It sits between board button pins and control logic, and replaces ad-hoc edge detection on raw inputs. Its outputs are single-cycle, clock-synchronous strobes suitable for direct use as enables.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before the debounced level changes; must be ≥1.
- `LONG_CYCLES`, default 1024: debounced-press duration in cycles that classifies a press as long; must be ≥2.
- `DOUBLE_GAP`, default 256: maximum release duration in cycles before a second press still counts as a double; must be ≥1.
- `BTN_ACTIVE`, default 1'b1: level of `btn` meaning "pressed". With 1'b0, the input is inverted after synchronisation.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (`rst`=0 resets).
- `btn` input 1: raw asynchronous button pin.
- `btn_db` output 1: debounced pressed level (1 = pressed).
- `short_press` output 1: one-cycle strobe, single press shorter than `LONG_CYCLES` with no follow-up.
- `long_press` output 1: one-cycle strobe, press held for `LONG_CYCLES`.
- `held` output 1: level, high from the long-press strobe until release.
- `double_press` output 1: one-cycle strobe, second press released within the window.

## Operation
- Input path:
  - 2-FF synchroniser on `btn`, then polarity normalisation by `BTN_ACTIVE`.
  - Debounce counter: cleared whenever the synchronised value equals `btn_db`, incremented otherwise.
  - On the edge where the counter reaches `DEBOUNCE_CYCLES`-1 while still differing, `btn_db` toggles and the counter clears.
- Classifier FSM, driven by `btn_db` only. One shared event counter, cleared on every state entry, incremented each cycle in a state and saturating at its maximum.
- **IDLE**: `btn_db`=1 → PRESS1.
- **PRESS1**:
  - `btn_db`=0 → WAIT2.
  - Counter reaches `LONG_CYCLES`-1 with `btn_db`=1 → assert `long_press`, then go to LONG_HELD.
- **LONG_HELD**: `held`=1. `btn_db`=0 → IDLE, with no further strobe.
- **WAIT2**:
  - `btn_db`=1 → PRESS2.
  - Counter reaches `DOUBLE_GAP`-1 with `btn_db`=0 → assert `short_press`, then go to IDLE.
- **PRESS2**: `btn_db`=0 → assert `double_press`, then go to IDLE. PRESS2 performs no long detection: holding the second press indefinitely still yields `double_press` on release.
- Simultaneous events:
  - In WAIT2, if the gap timeout and a new press coincide on the same edge, the press wins → PRESS2, and no `short_press` is issued.
  - In PRESS1, if the long threshold and a release coincide, the release wins → WAIT2.
- Exactly one strobe per classified gesture. Strobes are mutually exclusive and never last more than one cycle.
- Counter width: `$clog2(max(LONG_CYCLES, DOUBLE_GAP, DEBOUNCE_CYCLES)+1)` bits.

## Timing
- Reset values: synchroniser 0, debounce counter 0, `btn_db` 0, FSM IDLE, event counter 0. All strobes and `held` are 0.
- Reset asserted mid-gesture aborts the gesture immediately. After release, a button still held is re-qualified through the full debounce, then seen as a fresh press.
- `btn_db` latency: rises `2 + DEBOUNCE_CYCLES` edges after a clean `btn` transition.
- FSM and strobe latency:
  - FSM sees `btn_db` one edge later.
  - All outputs are registered; no combinational path from `btn` to any output.
- Strobe timing:
  - `long_press` asserts on the edge `LONG_CYCLES` cycles after FSM entry to PRESS1. `held` rises on that same edge.
  - `short_press` asserts `DOUBLE_GAP` cycles after entry to WAIT2.
  - `double_press` asserts one edge after `btn_db` falls in PRESS2.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach `btn_db` or the FSM.

## Structure
- Shared package `btn_sw_pkg` holds:
  - FSM state encodings: IDLE, PRESS1, LONG_HELD, WAIT2, PRESS2, 3-bit.
  - A width helper function for counters.
- One sub-module, `btn_debounce`, containing the synchroniser, polarity handling, debounce counter and `btn_db` output. The classifier FSM lives in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `DOUBLE_GAP`=10.
- **Bounce rejection:** `btn` toggles every 2 cycles for 30 cycles, then stays 0 → `btn_db` stays 0 and no strobe fires.
- **Short press:** clean press held 8 cycles, then released → one `short_press` pulse ≈10 cycles after FSM entry to WAIT2. No other strobe.
- **Long press:**
  - Press held 40 cycles → `long_press` pulse 20 cycles after PRESS1 entry.
  - `held`=1 until the FSM sees release, then 0.
  - No `short_press` or `double_press`.
- **Double press:**
  - Press 6 cycles, release 5, press 6, release → one `double_press` one edge after the second `btn_db` fall.
  - No `short_press`.
  - Also check that a second press held 50 cycles still gives `double_press` on release.
- **Gap boundary:**
  - Second press making `btn_db` rise exactly on the WAIT2 timeout edge → PRESS2, no `short_press`.
  - Second press one cycle later → `short_press`, then a fresh PRESS1.
- **Reset mid-operation:** `rst`=0 during LONG_HELD with `btn` held, released after 3 cycles → all outputs 0 during reset. `btn_db` re-rises after 2+4 edges, and the FSM restarts in PRESS1.
